// File: rtl/gmux_qen_ctrl.sv
// rtl/gmux_qen_ctrl.sv - per-quadrant static/dynamic/sleep enable sequencer for a global clock mux
module gmux_qen_ctrl #(
    parameter int ARM_CYC   = 4,
    parameter int DRAIN_CYC = 8,
    parameter int WAKE_CYC  = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mode_dyn,
    input  logic [3:0] gate_on,
    input  logic [3:0] sleep_req,
    output logic [3:0] sen,
    output logic [3:0] dynen,
    output logic [3:0] den,
    output logic [3:0] vlp,
    output logic [3:0] busy
);

    typedef enum logic [2:0] {
        ST_STATIC = 3'd0,
        ST_ARM    = 3'd1,
        ST_DYN    = 3'd2,
        ST_DISARM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_SLEEP  = 3'd5,
        ST_WAKE   = 3'd6
    } state_t;

    // Terminal counts: the exit fires on the cycle the dwell count reaches N-1.
    localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYC - 1);

    for (genvar q = 0; q < 4; q++) begin : g_quad
        state_t             state_q;
        state_t             state_d;
        logic [CNT_W-1:0]   cnt_q;
        logic               timed;
        logic               den_q;

        assign timed = (state_q == ST_ARM) || (state_q == ST_DISARM) ||
                       (state_q == ST_DRAIN) || (state_q == ST_WAKE);

        // State, dwell counter and gate register; reset drops straight to STATIC.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_STATIC;
                cnt_q   <= '0;
                den_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                if (state_d != state_q) begin
                    cnt_q <= '0;
                end else if (timed) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                // The gate only passes while staying in DYN, so DEN is 0 on
                // the first DYN cycle and from the first cycle after leaving it.
                den_q <= (state_q == ST_DYN) && (state_d == ST_DYN) && gate_on[q];
            end
        end

        // Next-state decode with request priority per state.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_STATIC: begin
                    if (sleep_req[q])     state_d = ST_DRAIN;
                    else if (mode_dyn[q]) state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (!mode_dyn[q])           state_d = ST_DISARM;
                    else if (cnt_q == ARM_LAST) state_d = ST_DYN;
                end
                ST_DYN: begin
                    if (sleep_req[q])      state_d = ST_DRAIN;
                    else if (!mode_dyn[q]) state_d = ST_DISARM;
                end
                ST_DISARM: begin
                    if (cnt_q == ARM_LAST) state_d = ST_STATIC;
                end
                ST_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) state_d = ST_SLEEP;
                end
                ST_SLEEP: begin
                    if (!sleep_req[q]) state_d = ST_WAKE;
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_LAST) state_d = ST_STATIC;
                end
                default: state_d = ST_STATIC;
            endcase
        end

        assign sen[q]   = (state_q == ST_STATIC) || (state_q == ST_ARM) || (state_q == ST_DISARM);
        assign dynen[q] = (state_q == ST_ARM) || (state_q == ST_DYN) || (state_q == ST_DISARM);
        assign den[q]   = den_q;
        assign vlp[q]   = (state_q == ST_SLEEP);
        assign busy[q]  = timed;
    end

endmodule
